// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared access-size codes, NOP word and FSM states for the CPU memory responder
package cpu_mem_pkg;

  // DMType encodings as driven by PipelineCPU; 101-111 behave as word accesses
  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF_S = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE_S = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  // addi x0, x0, 0 - returned for any fetch that does not hit loaded IMEM
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } resp_state_t;

endpackage

// File: rtl/dmem_lane_unit.sv
// rtl/dmem_lane_unit.sv - byte-lane steering for DMEM stores and sign/zero extension for loads
module dmem_lane_unit (
  input  logic [2:0]  i_dmtype,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);
  import cpu_mem_pkg::*;

  logic        w_is_half;
  logic        w_is_byte;
  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // decode access size, lane enables, replicated store data and extended load data
  always_comb begin
    w_is_half = (i_dmtype == DM_HALF_S) || (i_dmtype == DM_HALF_U);
    w_is_byte = (i_dmtype == DM_BYTE_S) || (i_dmtype == DM_BYTE_U);

    // bytes never misalign; halves need bit 0 clear; everything else is a word
    if (w_is_byte)      o_misalign = 1'b0;
    else if (w_is_half) o_misalign = i_addr_lo[0];
    else                o_misalign = (i_addr_lo != 2'b00);

    o_be    = 4'b1111;
    o_wdata = i_wdata;
    if (w_is_half) begin
      o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
      o_wdata = {2{i_wdata[15:0]}};
    end else if (w_is_byte) begin
      o_be    = 4'b0001 << i_addr_lo;
      o_wdata = {4{i_wdata[7:0]}};
    end
    if (o_misalign) o_be = 4'b0000;

    w_half  = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
    w_byte  = i_rword[{i_addr_lo, 3'b000} +: 8];
    o_rdata = i_rword;
    case (i_dmtype)
      DM_HALF_S: o_rdata = {{16{w_half[15]}}, w_half};
      DM_HALF_U: o_rdata = {16'h0000, w_half};
      DM_BYTE_S: o_rdata = {{24{w_byte[7]}}, w_byte};
      DM_BYTE_U: o_rdata = {24'h000000, w_byte};
      default:   o_rdata = i_rword;
    endcase
    if (o_misalign) o_rdata = 32'h0000_0000;
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - IMEM loader/CPU reset sequencer plus instruction and data memory for PipelineCPU
module cpu_mem_responder #(
  parameter int          IMEM_DEPTH  = 256,
  parameter int          DMEM_DEPTH  = 256,
  parameter int          HOLD_CYCLES = 4,
  parameter logic [31:0] NOP_INSTR   = cpu_mem_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        cpu_rst,
  output logic        run,
  input  logic [31:0] PC_out,
  output logic [31:0] instr_in,
  input  logic [31:0] Addr_out,
  input  logic [31:0] Data_out,
  input  logic        mem_w,
  input  logic [2:0]  DMType_out,
  output logic [31:0] Data_in,
  output logic        misalign_err,
  output logic        load_err
);
  import cpu_mem_pkg::*;

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int PW  = IAW + 1;
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam int HW  = $clog2(HOLD_CYCLES + 1);

  resp_state_t   r_state;
  logic [PW-1:0] r_ld_ptr;
  logic [HW-1:0] r_hold_cnt;
  logic          r_cpu_rst;
  logic          r_run;
  logic          r_ld_ready;
  logic          r_misalign_err;
  logic          r_load_err;
  logic [31:0]   r_imem [IMEM_DEPTH];
  logic [31:0]   r_dmem [DMEM_DEPTH];

  logic           w_ld_fire;
  logic           w_store;
  logic           w_misalign;
  logic           w_fetch_ok;
  logic [IAW-1:0] w_fetch_idx;
  logic [DAW-1:0] w_dmem_idx;
  logic [3:0]     w_be;
  logic [31:0]    w_wdata_rep;
  logic [31:0]    w_rword;
  logic           w_unused_addr;

  // a loader word is taken only while rst is released so the reset edge never writes IMEM
  assign w_ld_fire   = rst && (r_state == LOAD) && r_ld_ready && ld_valid;
  assign w_store     = rst && (r_state == RUN) && mem_w && !w_misalign;
  assign w_dmem_idx  = Addr_out[DAW+1:2];
  assign w_rword     = r_dmem[w_dmem_idx];
  assign w_fetch_idx = PC_out[IAW+1:2];
  // ld_ptr doubles as the valid limit: words at or above it were never loaded this session
  assign w_fetch_ok  = (r_state == RUN) && (PC_out[1:0] == 2'b00)
                     && (PC_out[31:2] < 30'(IMEM_DEPTH))
                     && ({1'b0, w_fetch_idx} < r_ld_ptr);
  assign instr_in    = w_fetch_ok ? r_imem[w_fetch_idx] : NOP_INSTR;
  assign w_unused_addr = ^Addr_out[31:DAW+2];

  assign ld_ready     = r_ld_ready;
  assign cpu_rst      = r_cpu_rst;
  assign run          = r_run;
  assign misalign_err = r_misalign_err;
  assign load_err     = r_load_err;

  dmem_lane_unit u_lanes (
    .i_dmtype   (DMType_out),
    .i_addr_lo  (Addr_out[1:0]),
    .i_wdata    (Data_out),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wdata    (w_wdata_rep),
    .o_rdata    (Data_in),
    .o_misalign (w_misalign)
  );

  // loader -> hold -> run sequencing with registered CPU-facing outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= LOAD;
      r_ld_ptr       <= '0;
      r_hold_cnt     <= '0;
      r_cpu_rst      <= 1'b1;
      r_run          <= 1'b0;
      r_ld_ready     <= 1'b0;
      r_misalign_err <= 1'b0;
      r_load_err     <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_ld_ready <= 1'b1;
          if (w_ld_fire) begin
            r_ld_ptr <= r_ld_ptr + 1'b1;
            if (ld_last) begin
              r_state    <= HOLD;
              r_ld_ready <= 1'b0;
              r_hold_cnt <= '0;
            end else if (r_ld_ptr == PW'(IMEM_DEPTH - 1)) begin
              r_state    <= ERR;
              r_ld_ready <= 1'b0;
              r_load_err <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (r_hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            r_state   <= RUN;
            r_cpu_rst <= 1'b0;
            r_run     <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (w_misalign) r_misalign_err <= 1'b1;
        end
        default: begin
          r_cpu_rst  <= 1'b1;
          r_ld_ready <= 1'b0;
        end
      endcase
    end
  end

  // IMEM fill from the loader stream; contents survive reset
  always_ff @(posedge clk) begin
    if (w_ld_fire) r_imem[r_ld_ptr[IAW-1:0]] <= ld_data;
  end

  // DMEM byte-lane store; contents survive reset
  always_ff @(posedge clk) begin
    if (w_store) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_dmem[w_dmem_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - directed vector bench for cpu_mem_responder
module tb_cpu_mem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        cpu_rst;
  logic        run;
  logic [31:0] PC_out;
  logic [31:0] instr_in;
  logic [31:0] Addr_out;
  logic [31:0] Data_out;
  logic        mem_w;
  logic [2:0]  DMType_out;
  logic [31:0] Data_in;
  logic        misalign_err;
  logic        load_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        wr;
    logic [2:0]  dmt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } dvec_t;

  dvec_t vecs [20];

  always #5 clk = ~clk;

  cpu_mem_responder #(
    .IMEM_DEPTH (256),
    .DMEM_DEPTH (256),
    .HOLD_CYCLES(4),
    .NOP_INSTR  (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .cpu_rst     (cpu_rst),
    .run         (run),
    .PC_out      (PC_out),
    .instr_in    (instr_in),
    .Addr_out    (Addr_out),
    .Data_out    (Data_out),
    .mem_w       (mem_w),
    .DMType_out  (DMType_out),
    .Data_in     (Data_in),
    .misalign_err(misalign_err),
    .load_err    (load_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int n = 0;
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    while (!ld_ready && n < 20) begin
      step();
      n++;
    end
    if (!ld_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL ld_ready_timeout: got 0 expected 1");
    end
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (!run && n < 20) begin
      step();
      n++;
    end
    chk("run_timeout", run, 1'b1);
  endtask

  task automatic read(input logic [2:0] t, input logic [31:0] a);
    mem_w      = 1'b0;
    DMType_out = t;
    Addr_out   = a;
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 3'b000, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 3'b000, 32'h10,  32'h0,        1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 3'b011, 32'h13,  32'h0,        1'b1, 32'hFFFFFFDE};
    vecs[3]  = '{1'b0, 3'b100, 32'h13,  32'h0,        1'b1, 32'h000000DE};
    vecs[4]  = '{1'b0, 3'b001, 32'h12,  32'h0,        1'b1, 32'hFFFFDEAD};
    vecs[5]  = '{1'b0, 3'b010, 32'h10,  32'h0,        1'b1, 32'h0000BEEF};
    vecs[6]  = '{1'b0, 3'b011, 32'h10,  32'h0,        1'b1, 32'hFFFFFFEF};
    vecs[7]  = '{1'b0, 3'b100, 32'h11,  32'h0,        1'b1, 32'h000000BE};
    vecs[8]  = '{1'b0, 3'b001, 32'h10,  32'h0,        1'b1, 32'hFFFFBEEF};
    vecs[9]  = '{1'b1, 3'b100, 32'h11,  32'h12345655, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 3'b000, 32'h10,  32'h0,        1'b1, 32'hDEAD55EF};
    vecs[11] = '{1'b1, 3'b000, 32'h14,  32'h00000000, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 3'b010, 32'h16,  32'hFFFF1234, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 3'b000, 32'h14,  32'h0,        1'b1, 32'h12340000};
    vecs[14] = '{1'b0, 3'b101, 32'h14,  32'h0,        1'b1, 32'h12340000};
    vecs[15] = '{1'b0, 3'b000, 32'h410, 32'h0,        1'b1, 32'hDEAD55EF};
    vecs[16] = '{1'b0, 3'b010, 32'h16,  32'h0,        1'b1, 32'h00001234};
    vecs[17] = '{1'b1, 3'b011, 32'h17,  32'h000000A7, 1'b0, 32'h0};
    vecs[18] = '{1'b0, 3'b000, 32'h14,  32'h0,        1'b1, 32'hA7340000};
    vecs[19] = '{1'b0, 3'b011, 32'h17,  32'h0,        1'b1, 32'hFFFFFFA7};

    rst = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    PC_out = '0; Addr_out = '0; Data_out = '0; mem_w = 1'b0; DMType_out = 3'b000;

    // reset state
    step();
    step();
    chk("rst_cpu_rst", cpu_rst, 1'b1);
    chk("rst_run", run, 1'b0);
    chk("rst_ld_ready", ld_ready, 1'b0);
    chk("rst_misalign", misalign_err, 1'b0);
    chk("rst_load_err", load_err, 1'b0);
    rst = 1'b1;
    step();
    chk("ld_ready_after_rst", ld_ready, 1'b1);

    // three-word program, then exactly four hold cycles
    send(32'h00000013, 1'b0);
    send(32'h00100093, 1'b0);
    send(32'h00200113, 1'b1);
    chk("ld_ready_drop", ld_ready, 1'b0);
    chk("hold0_cpu_rst", cpu_rst, 1'b1);
    chk("hold0_run", run, 1'b0);
    PC_out = 32'h4;
    #1;
    chk("fetch_in_hold", instr_in, NOP);
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("hold%0d_cpu_rst", i), cpu_rst, 1'b1);
      chk($sformatf("hold%0d_run", i), run, 1'b0);
    end
    step();
    chk("run_up", run, 1'b1);
    chk("run_cpu_rst", cpu_rst, 1'b0);

    // instruction fetch
    PC_out = 32'h0;   #1; chk("fetch_0", instr_in, 32'h00000013);
    PC_out = 32'h4;   #1; chk("fetch_4", instr_in, 32'h00100093);
    PC_out = 32'h8;   #1; chk("fetch_8", instr_in, 32'h00200113);
    PC_out = 32'hC;   #1; chk("fetch_unloaded", instr_in, NOP);
    PC_out = 32'h6;   #1; chk("fetch_misaligned", instr_in, NOP);
    PC_out = 32'h404; #1; chk("fetch_out_of_range", instr_in, NOP);

    // data path vectors
    for (int i = 0; i < 20; i++) begin
      mem_w      = vecs[i].wr;
      DMType_out = vecs[i].dmt;
      Addr_out   = vecs[i].addr;
      Data_out   = vecs[i].wdata;
      #1;
      if (vecs[i].chk) chk($sformatf("vec%0d", i), Data_in, vecs[i].exp);
      step();
      mem_w = 1'b0;
    end
    chk("no_misalign_yet", misalign_err, 1'b0);

    // misaligned word store is dropped and flags sticky
    mem_w = 1'b1; DMType_out = 3'b000; Addr_out = 32'h4; Data_out = 32'h11111111;
    step();
    Addr_out = 32'h6; Data_out = 32'h22222222;
    #1;
    chk("misalign_data_in", Data_in, 32'h0);
    step();
    mem_w = 1'b0;
    chk("misalign_set", misalign_err, 1'b1);
    read(3'b000, 32'h4);
    chk("misalign_no_store", Data_in, 32'h11111111);
    step();
    step();
    chk("misalign_sticky", misalign_err, 1'b1);

    // mid-run reset, store attempt while loading, reload one word
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rerst_cpu_rst", cpu_rst, 1'b1);
    chk("rerst_run", run, 1'b0);
    chk("rerst_misalign", misalign_err, 1'b0);
    mem_w = 1'b1; DMType_out = 3'b000; Addr_out = 32'h10; Data_out = 32'hBAD0BAD0;
    step();
    mem_w = 1'b0;
    chk("rerst_ld_ready", ld_ready, 1'b1);
    send(32'h00500293, 1'b1);
    wait_run();
    read(3'b000, 32'h10);
    chk("dmem_kept_10", Data_in, 32'hDEAD55EF);
    read(3'b000, 32'h4);
    chk("dmem_kept_4", Data_in, 32'h11111111);
    PC_out = 32'h0; #1; chk("reload_fetch_0", instr_in, 32'h00500293);
    PC_out = 32'h4; #1; chk("reload_limit", instr_in, NOP);

    // IMEM overflow
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        chk("pre_overflow_err", load_err, 1'b0);
        chk("pre_overflow_ready", ld_ready, 1'b1);
      end
      send(32'(i), 1'b0);
    end
    chk("overflow_load_err", load_err, 1'b1);
    chk("overflow_ld_ready", ld_ready, 1'b0);
    chk("overflow_cpu_rst", cpu_rst, 1'b1);
    mem_w = 1'b1; DMType_out = 3'b000; Addr_out = 32'h10; Data_out = 32'h0;
    step();
    mem_w = 1'b0;
    step();
    step();
    read(3'b000, 32'h10);
    chk("err_store_ignored", Data_in, 32'hDEAD55EF);
    chk("err_run", run, 1'b0);
    chk("err_cpu_rst", cpu_rst, 1'b1);
    chk("err_load_err_held", load_err, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
